errmod_map_pipe: RTL and testbench

Pipelined, parametrised successor to the combinational error-modulo/mapping unit in the JPEG-LS regular-mode path. It accepts one (Ix, Px, context-sign) sample per cycle over a valid/ready handshake and applies sign correction, modulo-RANGE reduction and Golomb mapping across three registered stages. It emits both the reduced Errval (for context A/B/C/N update) and MErrval (for the Golomb coder). It sits between the predictor/context-lookup stage and the Golomb encoder.

---
 rtl/jpegls_pkg.sv | 41 ++++
 rtl/jpegls_pipe_reg.sv | 41 ++++
 rtl/errmod_map_pipe.sv | 92 +++++++++
 tb/tb_errmod_map_pipe.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/jpegls_pkg.sv
// ============================================================================
// Module      : jpegls_pkg
// Description : Shared JPEG-LS regular-mode constants and error-mapping helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jpegls_pkg;

    localparam int C_BPP_DEFAULT   = 8;
    localparam int C_RANGE_DEFAULT = 1 << C_BPP_DEFAULT;

    // Lossless modulo-RANGE reduction into [-RANGE/2, RANGE/2-1].
    function automatic int mod_reduce(input int diff, input int bpp);
        int rng;
        int r;
        rng = 1 << bpp;
        r   = diff;
        if (r < 0) begin
            r = r + rng;
        end
        if (r >= rng / 2) begin
            r = r - rng;
        end
        return r;
    endfunction

    // Golomb mapping; the special form applies to k==0 contexts with a negative bias.
    function automatic int map_err(input int e, input bit special);
        int m;
        if (special) begin
            m = (e >= 0) ? (2 * e + 1) : (-2 * (e + 1));
        end else begin
            m = (e >= 0) ? (2 * e) : (-2 * e - 1);
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jpegls_pipe_reg.sv
// ============================================================================
// Module      : jpegls_pipe_reg
// Description : Valid/data pipeline stage register with an advance enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jpegls_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_adv,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Data only moves with a valid sample so the last result stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/errmod_map_pipe.sv
// ============================================================================
// Module      : errmod_map_pipe
// Description : 3-stage elastic JPEG-LS error sign-fix, modulo reduction and
//               Golomb mapping. Macro ERRMAP_SPECIAL_MAP_EN enables the
//               k==0 / negative-bias special mapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module errmod_map_pipe
    import jpegls_pkg::*;
#(
    parameter int BPP = C_BPP_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [BPP-1:0] in_ix,
    input  logic [BPP-1:0] in_px,
    input  logic           in_sign,
    input  logic           in_kzero,
    input  logic           in_bneg,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [BPP-1:0] out_errval,
    output logic [BPP-1:0] out_merrval
);

    logic                  w_adv1, w_adv2, w_adv3;
    logic                  w_v1, w_v2, w_v3;
    logic [BPP:0]          w_diffRaw;
    logic signed [BPP:0]   w_diff;
    logic signed [BPP:0]   w_diffQ;
    logic signed [BPP-1:0] w_err;
    logic signed [BPP-1:0] w_errQ;
    logic [BPP-1:0]        w_merr;
    logic                  w_special;

    assign w_adv3   = out_ready | ~w_v3;
    assign w_adv2   = w_adv3 | ~w_v2;
    assign w_adv1   = w_adv2 | ~w_v1;
    assign in_ready = w_adv1;

    assign w_diffRaw = {1'b0, in_ix} - {1'b0, in_px};
    assign w_diff    = in_sign ? -w_diffRaw : w_diffRaw;
    assign w_err     = BPP'(mod_reduce(int'(w_diffQ), BPP));
    assign w_merr    = BPP'(map_err(int'(w_errQ), w_special));

`ifdef ERRMAP_SPECIAL_MAP_EN
    logic [BPP+2:0] w_s1Q;
    logic [BPP+1:0] w_s2Q;

    jpegls_pipe_reg #(.WIDTH(BPP + 3)) u_s1 (
        .clk(clk), .rst(rst), .i_adv(w_adv1), .i_valid(in_valid & w_adv1),
        .i_data({w_diff, in_kzero, in_bneg}), .o_valid(w_v1), .o_data(w_s1Q)
    );
    assign w_diffQ = w_s1Q[BPP+2:2];

    jpegls_pipe_reg #(.WIDTH(BPP + 2)) u_s2 (
        .clk(clk), .rst(rst), .i_adv(w_adv2), .i_valid(w_v1),
        .i_data({w_err, w_s1Q[1:0]}), .o_valid(w_v2), .o_data(w_s2Q)
    );
    assign w_errQ    = w_s2Q[BPP+1:2];
    assign w_special = w_s2Q[1] & w_s2Q[0];
`else
    // Flags are accepted for port compatibility but carry no state here.
    logic w_unusedFlags;
    assign w_unusedFlags = in_kzero ^ in_bneg;

    jpegls_pipe_reg #(.WIDTH(BPP + 1)) u_s1 (
        .clk(clk), .rst(rst), .i_adv(w_adv1), .i_valid(in_valid & w_adv1),
        .i_data(w_diff), .o_valid(w_v1), .o_data(w_diffQ)
    );

    jpegls_pipe_reg #(.WIDTH(BPP)) u_s2 (
        .clk(clk), .rst(rst), .i_adv(w_adv2), .i_valid(w_v1),
        .i_data(w_err), .o_valid(w_v2), .o_data(w_errQ)
    );
    assign w_special = 1'b0;
`endif

    jpegls_pipe_reg #(.WIDTH(2 * BPP)) u_s3 (
        .clk(clk), .rst(rst), .i_adv(w_adv3), .i_valid(w_v2),
        .i_data({w_errQ, w_merr}), .o_valid(w_v3), .o_data({out_errval, out_merrval})
    );

    assign out_valid = w_v3;

endmodule

`default_nettype wire

// File: tb/tb_errmod_map_pipe.sv
// ============================================================================
// Module      : tb_errmod_map_pipe
// Description : Directed self-checking bench for errmod_map_pipe (BPP = 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_errmod_map_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_sign = 1'b0;
    logic       in_kzero = 1'b0;
    logic       in_bneg = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_ix = 8'd0;
    logic [7:0] in_px = 8'd0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_errval;
    logic [7:0] out_merrval;

    int nVectors = 0;
    int nMiscompares = 0;

    int bpIx[6]   = '{5, 3, 50, 10, 127, 0};
    int bpPx[6]   = '{3, 5, 10, 50, 0, 127};
    int bpErr[6]  = '{2, -2, 40, -40, 127, -127};
    int bpMerr[6] = '{4, 3, 80, 79, 254, 253};

    errmod_map_pipe #(.BPP(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ix(in_ix), .in_px(in_px), .in_sign(in_sign),
        .in_kzero(in_kzero), .in_bneg(in_bneg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_errval(out_errval), .out_merrval(out_merrval)
    );

    always #5 clk = ~clk;

    function automatic int errS();
        return int'($signed(out_errval));
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        nVectors++;
        if (obs != expv) begin
            nMiscompares++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, expv);
        end
    endtask

    // One sample through an empty, unstalled pipe.
    task automatic runVec(input string tag, input int ix, input int px, input bit sgn,
                          input bit kz, input bit bn, input int expErr, input int expMerr);
        int lat;
        @(negedge clk);
        in_ix    = 8'(ix);
        in_px    = 8'(px);
        in_sign  = sgn;
        in_kzero = kz;
        in_bneg  = bn;
        in_valid = 1'b1;
        check({tag, "_rdy"}, int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, 3);
        check({tag, "_err"}, errS(), expErr);
        check({tag, "_merr"}, int'(out_merrval), expMerr);
    endtask

    initial begin
        int txIdx;
        int rxIdx;
        int heldErr;
        int heldMerr;
        int extra;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_ready", int'(in_ready), 1);
        check("rst_err", int'(out_errval), 0);
        check("rst_merr", int'(out_merrval), 0);

        runVec("basic", 200, 50, 1'b0, 1'b0, 1'b0, -106, 211);
        runVec("signed", 10, 20, 1'b1, 1'b0, 1'b0, 10, 20);
`ifdef ERRMAP_SPECIAL_MAP_EN
        runVec("spec_neg", 100, 103, 1'b0, 1'b1, 1'b1, -3, 4);
        runVec("spec_pos", 5, 3, 1'b0, 1'b1, 1'b1, 2, 5);
`else
        runVec("spec_neg", 100, 103, 1'b0, 1'b1, 1'b1, -3, 5);
        runVec("spec_pos", 5, 3, 1'b0, 1'b1, 1'b1, 2, 4);
`endif
        runVec("kz_only", 100, 103, 1'b0, 1'b1, 1'b0, -3, 5);
        runVec("wrap_lo", 0, 255, 1'b0, 1'b0, 1'b0, 1, 2);
        runVec("wrap_hi", 255, 0, 1'b0, 1'b0, 1'b0, -1, 1);
        runVec("wrap_mid", 128, 0, 1'b0, 1'b0, 1'b0, -128, 255);

        // Back-pressure: five stalled cycles, then release.
        txIdx = 0;
        rxIdx = 0;
        heldErr = 0;
        heldMerr = 0;
        for (int cyc = 0; cyc < 40 && rxIdx < 6; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            #1;
            if (cyc == 3) begin
                check("bp_full_rdy", int'(in_ready), 0);
                check("bp_full_valid", int'(out_valid), 1);
                heldErr  = errS();
                heldMerr = int'(out_merrval);
            end
            if (cyc == 4) begin
                check("bp_hold_rdy", int'(in_ready), 0);
                check("bp_hold_err", errS(), heldErr);
                check("bp_hold_merr", int'(out_merrval), heldMerr);
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp_err%0d", rxIdx), errS(), bpErr[rxIdx]);
                check($sformatf("bp_merr%0d", rxIdx), int'(out_merrval), bpMerr[rxIdx]);
                rxIdx++;
            end
            if (txIdx < 6) begin
                in_ix    = 8'(bpIx[txIdx]);
                in_px    = 8'(bpPx[txIdx]);
                in_sign  = 1'b0;
                in_kzero = 1'b0;
                in_bneg  = 1'b0;
                in_valid = 1'b1;
                if (in_ready) begin
                    txIdx++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("bp_count", rxIdx, 6);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("bp_nodup", extra, 0);

        // Reset with a full pipe.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_ix    = 8'(i + 1);
            in_px    = 8'd0;
            in_valid = 1'b1;
        end
        @(negedge clk);
        check("mid_full_valid", int'(out_valid), 1);
        in_ix = 8'd9;
        rst   = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        check("mid_rst_err", int'(out_errval), 0);
        check("mid_rst_merr", int'(out_merrval), 0);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("mid_rst_stale", extra, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

`default_nettype wire
